// File: rtl/bpu_update_queue_pkg.sv
// Shared types for the BPU commit-time update queue.
package bpu_update_queue_pkg;

    localparam int unsigned PLEN = 32;

    // One branch-resolution record as consumed by the BPU update port.
    typedef struct packed {
        logic [PLEN-1:0] pc;
        logic            is_cond;
        logic            taken;
        logic [PLEN-1:0] target;
        logic            is_call;
        logic            is_ret;
    } bpu_update_t;

endpackage

// File: rtl/bpu_updq_compact.sv
// Prefix-popcount packer: maps sparse commit slots to dense write offsets.
module bpu_updq_compact #(
    parameter int unsigned COMMIT_WIDTH = 4,
    localparam int unsigned NP_W = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic [COMMIT_WIDTH-1:0]           valid_i,
    output logic [COMMIT_WIDTH-1:0][NP_W-1:0] offset_o,
    output logic [NP_W-1:0]                   npush_o
);

    logic [NP_W-1:0] run_c;

    // Each slot's offset is the number of valid slots older than it.
    always_comb begin
        run_c    = '0;
        offset_o = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            offset_o[i] = run_c;
            run_c       = run_c + NP_W'(valid_i[i]);
        end
    end

    assign npush_o = run_c;

endmodule

// File: rtl/bpu_update_queue.sv
// Order-preserving queue sharing the single BPU update port among the commit slots.
// Optional feature: define BPU_UPDQ_BYPASS_EN to issue the oldest record of a group
// pushed into an empty, draining queue in the same cycle.
module bpu_update_queue
    import bpu_update_queue_pkg::*;
#(
    parameter int unsigned COMMIT_WIDTH = 4,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [COMMIT_WIDTH-1:0]           commit_valid_i,
    input  bpu_update_t [COMMIT_WIDTH-1:0]    commit_upd_i,
    output logic                              commit_ready_o,
    input  logic                              drain_en_i,
    output logic                              update_valid_o,
    output logic [PLEN-1:0]                   update_pc_o,
    output logic                              update_is_cond_o,
    output logic                              update_taken_o,
    output logic [PLEN-1:0]                   update_target_o,
    output logic                              update_is_call_o,
    output logic                              update_is_ret_o,
    output logic [$clog2(DEPTH+1)-1:0]        occupancy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned NP_W  = $clog2(COMMIT_WIDTH + 1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    bpu_update_t      mem_q [DEPTH];

    logic [COMMIT_WIDTH-1:0]           acc_valid;
    logic [COMMIT_WIDTH-1:0][NP_W-1:0] offset;
    logic [NP_W-1:0]                   npush;
    logic [NP_W-1:0]                   nwrite;
    logic                              pop;
    logic                              bypass;
    bpu_update_t                       out_upd;
    logic [COMMIT_WIDTH-1:0]           wr_en;
    logic [COMMIT_WIDTH-1:0][PTR_W-1:0] wr_idx;

    // Room for a whole group depends only on count, never on the valids.
    assign commit_ready_o = (count_q <= CNT_W'(DEPTH - COMMIT_WIDTH));
    assign acc_valid      = commit_ready_o ? commit_valid_i : '0;
    assign pop            = drain_en_i && (count_q != '0);

    bpu_updq_compact #(
        .COMMIT_WIDTH (COMMIT_WIDTH)
    ) u_compact (
        .valid_i  (acc_valid),
        .offset_o (offset),
        .npush_o  (npush)
    );

`ifdef BPU_UPDQ_BYPASS_EN
    bpu_update_t first_upd;

    assign bypass = (|acc_valid) && drain_en_i && (count_q == '0);

    // Oldest valid slot of the incoming group, used for the same-cycle issue.
    always_comb begin
        first_upd = commit_upd_i[0];
        for (int i = COMMIT_WIDTH - 1; i >= 0; i--) begin
            if (commit_valid_i[i]) begin
                first_upd = commit_upd_i[i];
            end
        end
    end

    assign out_upd = bypass ? first_upd : mem_q[rd_ptr_q];
`else
    assign bypass  = 1'b0;
    assign out_upd = mem_q[rd_ptr_q];
`endif

    assign update_valid_o   = pop | bypass;
    assign update_pc_o      = out_upd.pc;
    assign update_is_cond_o = out_upd.is_cond;
    assign update_taken_o   = out_upd.taken;
    assign update_target_o  = out_upd.target;
    assign update_is_call_o = out_upd.is_call;
    assign update_is_ret_o  = out_upd.is_ret;
    assign occupancy_o      = count_q;

    // A bypassed record is not stored, so later slots shift down by one.
    always_comb begin
        wr_en  = '0;
        wr_idx = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            wr_en[i]  = acc_valid[i] && !(bypass && (offset[i] == '0));
            wr_idx[i] = wr_ptr_q + PTR_W'(offset[i]) - PTR_W'(bypass);
        end
    end

    assign nwrite   = npush - NP_W'(bypass);
    assign count_d  = count_q + CNT_W'(nwrite) - CNT_W'(pop);
    assign wr_ptr_d = wr_ptr_q + PTR_W'(nwrite);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);

    // Pointer and count state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; payloads need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_idx[i]] <= commit_upd_i[i];
            end
        end
    end

endmodule

// File: tb/tb_bpu_update_queue.sv
// Self-checking bench for bpu_update_queue with a queue-based reference model.
// Honours BPU_UPDQ_BYPASS_EN when the design is built with it.
module tb_bpu_update_queue;
    import bpu_update_queue_pkg::*;

    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef bpu_update_t [CW-1:0] grp_t;

    typedef struct {
        logic          rst_before;
        logic [CW-1:0] valid;
        logic          drain;
        logic          exp_ready;
        logic          exp_uvalid;
        int            exp_occ;
    } vec_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [CW-1:0]    commit_valid_i;
    grp_t             commit_upd_i;
    logic             commit_ready_o;
    logic             drain_en_i;
    logic             update_valid_o;
    logic [PLEN-1:0]  update_pc_o;
    logic             update_is_cond_o;
    logic             update_taken_o;
    logic [PLEN-1:0]  update_target_o;
    logic             update_is_call_o;
    logic             update_is_ret_o;
    logic [CNT_W-1:0] occupancy_o;

    bpu_update_t      model[$];
    logic [PLEN-1:0]  issued_pc[$];
    int               checks = 0;
    int               errors = 0;
    logic             obs_ready, obs_valid;
    logic [PLEN-1:0]  obs_pc;
    logic [CNT_W-1:0] obs_occ;
    vec_t             tbl[11];

    always #5 clk_i = ~clk_i;

    bpu_update_queue #(.COMMIT_WIDTH(CW), .DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .commit_valid_i   (commit_valid_i),
        .commit_upd_i     (commit_upd_i),
        .commit_ready_o   (commit_ready_o),
        .drain_en_i       (drain_en_i),
        .update_valid_o   (update_valid_o),
        .update_pc_o      (update_pc_o),
        .update_is_cond_o (update_is_cond_o),
        .update_taken_o   (update_taken_o),
        .update_target_o  (update_target_o),
        .update_is_call_o (update_is_call_o),
        .update_is_ret_o  (update_is_ret_o),
        .occupancy_o      (occupancy_o)
    );

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic grp_t rand_group();
        grp_t g;
        for (int i = 0; i < CW; i++) begin
            g[i].pc      = PLEN'($urandom);
            g[i].is_cond = 1'($urandom);
            g[i].taken   = 1'($urandom);
            g[i].target  = PLEN'($urandom);
            g[i].is_call = 1'($urandom);
            g[i].is_ret  = 1'($urandom);
        end
        return g;
    endfunction

    function automatic bpu_update_t mk(input logic [PLEN-1:0] pc, input logic c, input logic t,
                                       input logic [PLEN-1:0] tg, input logic call, input logic ret);
        bpu_update_t u;
        u.pc = pc; u.is_cond = c; u.taken = t; u.target = tg; u.is_call = call; u.is_ret = ret;
        return u;
    endfunction

    // One clock: drive, check against the model at negedge, advance the model.
    task automatic cycle(input logic [CW-1:0] v, input grp_t u, input logic d);
        logic        exp_ready, exp_valid, byp, skip;
        bpu_update_t exp_u, got_u;
        commit_valid_i = v;
        commit_upd_i   = u;
        drain_en_i     = d;
        @(negedge clk_i);
        exp_ready = (DEPTH - model.size()) >= CW;
        byp = 1'b0;
`ifdef BPU_UPDQ_BYPASS_EN
        byp = exp_ready && (v != '0) && d && (model.size() == 0);
`endif
        exp_valid = (d && model.size() != 0) || byp;
        exp_u = '0;
        if (byp) begin
            for (int i = CW - 1; i >= 0; i--) if (v[i]) exp_u = u[i];
        end else if (model.size() != 0) begin
            exp_u = model[0];
        end
        got_u = {update_pc_o, update_is_cond_o, update_taken_o, update_target_o,
                 update_is_call_o, update_is_ret_o};
        obs_ready = commit_ready_o;
        obs_valid = update_valid_o;
        obs_pc    = update_pc_o;
        obs_occ   = occupancy_o;
        chk("commit_ready", commit_ready_o, exp_ready);
        chk("update_valid", update_valid_o, exp_valid);
        chk("occupancy", occupancy_o, model.size());
        if (exp_valid) chk("update_payload", got_u, exp_u);
        if (update_valid_o) issued_pc.push_back(update_pc_o);
        if (d && model.size() != 0) void'(model.pop_front());
        if (exp_ready) begin
            skip = byp;
            for (int i = 0; i < CW; i++) begin
                if (v[i]) begin
                    if (skip) skip = 1'b0;
                    else model.push_back(u[i]);
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        commit_valid_i = '0;
        drain_en_i     = 1'b0;
        rst_i          = 1'b1;
        #1;
        chk("rst_ready", commit_ready_o, 1'b1);
        chk("rst_valid", update_valid_o, 1'b0);
        chk("rst_occ", occupancy_o, 0);
        @(posedge clk_i);
        #2 rst_i = 1'b0;
        model.delete();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        grp_t g;
        int   guard;

        rst_i          = 1'b0;
        commit_valid_i = '0;
        commit_upd_i   = '0;
        drain_en_i     = 1'b0;
        #2;
        do_reset();

        // Full/back-pressure then drain gating, table driven.
        tbl[0]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 4};
        tbl[1]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 8};
        tbl[2]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 12};
        tbl[3]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 16};
        tbl[4]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 16};
        tbl[5]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 16};
        tbl[6]  = '{1'b1, 4'b0111, 1'b0, 1'b1, 1'b0, 3};
        tbl[7]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 2};
        tbl[8]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2};
        tbl[9]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1};
        tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 0};
        for (int k = 0; k < 11; k++) begin
            if (tbl[k].rst_before) do_reset();
            cycle(tbl[k].valid, rand_group(), tbl[k].drain);
            chk("tbl_ready", obs_ready, tbl[k].exp_ready);
            chk("tbl_uvalid", obs_valid, tbl[k].exp_uvalid);
            chk("tbl_occ", occupancy_o, tbl[k].exp_occ);
        end

        // Sparse pack of slots 1 and 3.
        do_reset();
        g = rand_group();
        g[1].pc = 32'h100;
        g[3].pc = 32'h10C;
        cycle(4'b1010, g, 1'b0);
        cycle(4'b0000, rand_group(), 1'b0);
        chk("sparse_occ", obs_occ, 2);
        cycle(4'b0000, rand_group(), 1'b1);
        chk("sparse_v0", obs_valid, 1'b1);
        chk("sparse_pc0", obs_pc, 32'h100);
        cycle(4'b0000, rand_group(), 1'b1);
        chk("sparse_v1", obs_valid, 1'b1);
        chk("sparse_pc1", obs_pc, 32'h10C);
        cycle(4'b0000, rand_group(), 1'b1);
        chk("sparse_empty", obs_valid, 1'b0);

        // Move pointers to 14, then push a group that straddles the wrap while draining.
        do_reset();
        cycle(4'b1111, rand_group(), 1'b1);
        cycle(4'b1111, rand_group(), 1'b1);
        cycle(4'b1111, rand_group(), 1'b1);
        cycle(4'b0011, rand_group(), 1'b1);
        guard = 0;
        while (model.size() != 0 && guard < 40) begin
            cycle(4'b0000, rand_group(), 1'b1);
            guard++;
        end
        chk("wrap_predrain_empty", occupancy_o, 0);
        issued_pc.delete();
        g[0] = mk(32'h200, 1'b0, 1'b1, 32'h800, 1'b1, 1'b0);
        g[1] = mk(32'h300, 1'b0, 1'b1, 32'h204, 1'b0, 1'b1);
        g[2] = mk(32'h304, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0);
        g[3] = mk(32'h308, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0);
        cycle(4'b1111, g, 1'b1);
        for (int k = 0; k < 4; k++) cycle(4'b0000, rand_group(), 1'b1);
        chk("wrap_count", issued_pc.size(), 4);
        if (issued_pc.size() == 4) begin
            chk("wrap_pc0", issued_pc[0], 32'h200);
            chk("wrap_pc1", issued_pc[1], 32'h300);
            chk("wrap_pc2", issued_pc[2], 32'h304);
            chk("wrap_pc3", issued_pc[3], 32'h308);
        end

        // Bypass behaviour on an empty, draining queue.
        do_reset();
        g = rand_group();
        g[0].pc = 32'h500;
        g[1].pc = 32'h504;
        cycle(4'b0011, g, 1'b1);
`ifdef BPU_UPDQ_BYPASS_EN
        chk("byp_valid", obs_valid, 1'b1);
        chk("byp_pc", obs_pc, 32'h500);
        chk("byp_occ", occupancy_o, 1);
`else
        chk("nobyp_valid", obs_valid, 1'b0);
        chk("nobyp_occ", occupancy_o, 2);
`endif

        // Reset while draining with five entries queued.
        do_reset();
        cycle(4'b1111, rand_group(), 1'b0);
        cycle(4'b0001, rand_group(), 1'b0);
        chk("midrst_pre_occ", occupancy_o, 5);
        commit_valid_i = '0;
        drain_en_i     = 1'b1;
        #2 rst_i = 1'b1;
        #1;
        chk("midrst_valid", update_valid_o, 1'b0);
        chk("midrst_occ", occupancy_o, 0);
        chk("midrst_ready", commit_ready_o, 1'b1);
        @(posedge clk_i);
        #2 rst_i = 1'b0;
        model.delete();
        @(posedge clk_i);
        #1;
        cycle(4'b0000, rand_group(), 1'b1);

        // Randomised traffic against the model: low then high drain rates.
        do_reset();
        for (int k = 0; k < 800; k++) begin
            cycle(CW'($urandom), rand_group(),
                  ($urandom_range(0, 99) < ((k < 400) ? 30 : 85)) ? 1'b1 : 1'b0);
        end
        for (int k = 0; k < 20; k++) cycle(4'b0000, rand_group(), 1'b1);
        chk("final_empty", occupancy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
